// File: rtl/barrel_frame_sequencer_if.sv
// Request channel between barrel_frame_sequencer (master) and the memory interface request port (slave).
interface barrel_frame_sequencer_if #(
   parameter int COORD_W = 12
);
   logic [COORD_W-1:0] req_x;
   logic [COORD_W-1:0] req_y;
   logic               req_valid;
   logic               req_ready;
   logic               req_sof;
   logic               req_eol;

   modport master (output req_x, req_y, req_valid, req_sof, req_eol, input req_ready);
   modport slave  (input req_x, req_y, req_valid, req_sof, req_eol, output req_ready);
endinterface

// File: rtl/barrel_frame_sequencer.sv
// Walks the output raster issuing one (x, y) request per pixel, gated on buffer fill and downstream ready.
// Optional stall counter output enabled by defining BARREL_SEQ_STALL_CNT_EN.
module barrel_frame_sequencer #(
   parameter int WIDTH   = 1080,
   parameter int HEIGHT  = 960,
   parameter int COORD_W = 12
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   input  logic                      buf_ready,
   barrel_frame_sequencer_if.master  req,
   output logic                      frame_done,
   output logic [15:0]               frame_count,
   output logic                      busy
`ifdef BARREL_SEQ_STALL_CNT_EN
   ,
   output logic [31:0]               stall_count
`endif
);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_FILL,
      RUN,
      FRAME_END
   } state_t;

   localparam logic [COORD_W-1:0] X_LAST = COORD_W'(WIDTH - 1);
   localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(HEIGHT - 1);

   state_t             state;
   state_t             state_next;
   logic [COORD_W-1:0] x;
   logic [COORD_W-1:0] y;
   logic [COORD_W-1:0] x_next;
   logic [COORD_W-1:0] y_next;
   logic               held;
   logic               held_next;
   logic               valid;
   logic               xfer;

   // A raised request stays up (held) until it transfers, regardless of buf_ready
   assign valid = (state == RUN) && (held || buf_ready);
   assign xfer  = valid && req.req_ready;

   always_comb begin
      state_next = state;
      x_next     = x;
      y_next     = y;
      held_next  = held;
      case (state)
         IDLE: begin
            held_next = 1'b0;
            if (enable) state_next = WAIT_FILL;
         end
         WAIT_FILL: begin
            x_next    = '0;
            y_next    = '0;
            held_next = 1'b0;
            if (buf_ready) state_next = RUN;
         end
         RUN: begin
            if (xfer) begin
               held_next = 1'b0;
               if (x != X_LAST) begin
                  x_next = x + 1'b1;
               end else if (y != Y_LAST) begin
                  x_next = '0;
                  y_next = y + 1'b1;
               end else begin
                  state_next = FRAME_END;
               end
            end else begin
               held_next = valid;
            end
         end
         FRAME_END: begin
            x_next     = '0;
            y_next     = '0;
            held_next  = 1'b0;
            state_next = enable ? WAIT_FILL : IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         x           <= '0;
         y           <= '0;
         held        <= 1'b0;
         frame_count <= '0;
      end else begin
         state <= state_next;
         x     <= x_next;
         y     <= y_next;
         held  <= held_next;
         if (state == FRAME_END) frame_count <= frame_count + 16'd1;
      end
   end

`ifdef BARREL_SEQ_STALL_CNT_EN
   // Counts RUN cycles starved by the buffer; a held request never counts since valid stays high
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_count <= '0;
      end else if (state == IDLE && state_next == WAIT_FILL) begin
         stall_count <= '0;
      end else if (state == RUN && !valid && stall_count != '1) begin
         stall_count <= stall_count + 32'd1;
      end
   end
`endif

   assign req.req_valid = valid;
   assign req.req_x     = x;
   assign req.req_y     = y;
   assign req.req_sof   = valid && (x == '0) && (y == '0);
   assign req.req_eol   = valid && (x == X_LAST);
   assign frame_done    = (state == FRAME_END);
   assign busy          = (state != IDLE);

endmodule

// File: tb/tb_barrel_frame_sequencer.sv
// Self-checking bench for barrel_frame_sequencer on a 4x3 raster, directed scenarios plus a randomized run.
module tb_barrel_frame_sequencer;
   localparam int W  = 4;
   localparam int H  = 3;
   localparam int CW = 12;
   localparam int NPIX = W * H;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic        buf_ready = 1'b0;
   logic        frame_done;
   logic        busy;
   logic [15:0] frame_count;
`ifdef BARREL_SEQ_STALL_CNT_EN
   logic [31:0] stall_count;
`endif
   int checks = 0;
   int fails  = 0;

   barrel_frame_sequencer_if #(.COORD_W(CW)) req_if ();

   barrel_frame_sequencer #(.WIDTH(W), .HEIGHT(H), .COORD_W(CW)) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .buf_ready   (buf_ready),
      .req         (req_if),
      .frame_done  (frame_done),
      .frame_count (frame_count),
      .busy        (busy)
`ifdef BARREL_SEQ_STALL_CNT_EN
      ,
      .stall_count (stall_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic en, input logic br, input logic rr);
      enable           = en;
      buf_ready        = br;
      req_if.req_ready = rr;
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b0);
      step();
      step();
      reset = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(1'b1, 1'b1, 1'b1);
      step();
      step();
      checks++; if (req_if.req_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", req_if.req_valid); end
      checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (frame_done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", frame_done); end
      checks++; if (frame_count !== 16'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", frame_count); end
      checks++; if (req_if.req_x !== '0 || req_if.req_y !== '0) begin fails++; $display("FAIL reset_xy: got (%0d,%0d) expected (0,0)", req_if.req_x, req_if.req_y); end
      checks++; if (req_if.req_sof !== 1'b0 || req_if.req_eol !== 1'b0) begin fails++; $display("FAIL reset_flags: got sof=%b eol=%b expected 0 0", req_if.req_sof, req_if.req_eol); end
`ifdef BARREL_SEQ_STALL_CNT_EN
      checks++; if (stall_count !== 32'd0) begin fails++; $display("FAIL reset_stall: got %0d expected 0", stall_count); end
`endif
      reset = 1'b0;
      drive(1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_basic_frame();
      int k = 0;
      int first = -1;
      int last = -1;
      do_reset();
      drive(1'b1, 1'b1, 1'b1);
      for (int c = 0; c < 40 && k < NPIX; c++) begin
         if (req_if.req_valid && req_if.req_ready) begin
            checks++;
            if (req_if.req_x !== CW'(k % W) || req_if.req_y !== CW'(k / W) ||
                req_if.req_sof !== (k == 0) || req_if.req_eol !== (k % W == W - 1)) begin
               fails++;
               $display("FAIL basic_pixel%0d: got (%0d,%0d) sof=%b eol=%b expected (%0d,%0d) sof=%b eol=%b", k,
                        req_if.req_x, req_if.req_y, req_if.req_sof, req_if.req_eol, k % W, k / W, k == 0, k % W == W - 1);
            end
            if (first < 0) first = c;
            last = c;
            k++;
         end
         step();
      end
      checks++; if (k != NPIX) begin fails++; $display("FAIL basic_xfers: got %0d expected %0d", k, NPIX); end
      checks++; if (last - first != NPIX - 1) begin fails++; $display("FAIL basic_back_to_back: got span %0d expected %0d", last - first, NPIX - 1); end
      drive(1'b0, 1'b1, 1'b1);
      checks++; if (frame_done !== 1'b1) begin fails++; $display("FAIL basic_done_pulse: got %b expected 1", frame_done); end
      checks++; if (req_if.req_valid !== 1'b0) begin fails++; $display("FAIL basic_end_valid: got %b expected 0", req_if.req_valid); end
      step();
      checks++; if (frame_done !== 1'b0) begin fails++; $display("FAIL basic_done_width: got %b expected 0", frame_done); end
      checks++; if (frame_count !== 16'd1) begin fails++; $display("FAIL basic_count: got %0d expected 1", frame_count); end
      checks++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_idle: got busy=%b expected 0", busy); end
   endtask

   task automatic test_fill_wait();
      do_reset();
      drive(1'b1, 1'b0, 1'b1);
      step();
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (busy !== 1'b1 || req_if.req_valid !== 1'b0) begin
            fails++;
            $display("FAIL fill_wait_cycle%0d: got busy=%b valid=%b expected busy=1 valid=0", i, busy, req_if.req_valid);
         end
         step();
      end
      drive(1'b1, 1'b1, 1'b1);
      checks++; if (req_if.req_valid !== 1'b0) begin fails++; $display("FAIL fill_rise_same_cycle: got valid=%b expected 0", req_if.req_valid); end
      step();
      checks++;
      if (req_if.req_valid !== 1'b1 || req_if.req_x !== '0 || req_if.req_y !== '0 || req_if.req_sof !== 1'b1) begin
         fails++;
         $display("FAIL fill_first_req: got valid=%b (%0d,%0d) sof=%b expected valid=1 (0,0) sof=1",
                  req_if.req_valid, req_if.req_x, req_if.req_y, req_if.req_sof);
      end
   endtask

   task automatic test_backpressure();
      bit found = 0;
      do_reset();
      drive(1'b1, 1'b1, 1'b1);
      for (int c = 0; c < 40; c++) begin
         if (req_if.req_valid && req_if.req_x == CW'(2) && req_if.req_y == CW'(1)) begin
            found = 1;
            break;
         end
         step();
      end
      checks++; if (!found) begin fails++; $display("FAIL bp_reach: got found=0 expected 1"); end
      drive(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         if (i == 2) drive(1'b1, 1'b0, 1'b0);
         if (i == 4) drive(1'b1, 1'b1, 1'b0);
         checks++;
         if (req_if.req_valid !== 1'b1 || req_if.req_x !== CW'(2) || req_if.req_y !== CW'(1) || req_if.req_eol !== 1'b0) begin
            fails++;
            $display("FAIL bp_hold%0d: got valid=%b (%0d,%0d) eol=%b expected valid=1 (2,1) eol=0",
                     i, req_if.req_valid, req_if.req_x, req_if.req_y, req_if.req_eol);
         end
         step();
      end
      drive(1'b1, 1'b1, 1'b1);
      step();
      checks++;
      if (req_if.req_valid !== 1'b1 || req_if.req_x !== CW'(3) || req_if.req_y !== CW'(1) || req_if.req_eol !== 1'b1) begin
         fails++;
         $display("FAIL bp_next: got valid=%b (%0d,%0d) eol=%b expected valid=1 (3,1) eol=1",
                  req_if.req_valid, req_if.req_x, req_if.req_y, req_if.req_eol);
      end
   endtask

   task automatic test_stop_at_boundary();
      int k = 0;
      int pulses = 0;
      do_reset();
      drive(1'b1, 1'b1, 1'b1);
      for (int c = 0; c < 40; c++) begin
         if (enable && req_if.req_valid && req_if.req_x == CW'(1) && req_if.req_y == CW'(1)) drive(1'b0, 1'b1, 1'b1);
         if (req_if.req_valid && req_if.req_ready) begin
            checks++;
            if (req_if.req_x !== CW'(k % W) || req_if.req_y !== CW'(k / W)) begin
               fails++;
               $display("FAIL stop_pixel%0d: got (%0d,%0d) expected (%0d,%0d)", k, req_if.req_x, req_if.req_y, k % W, k / W);
            end
            k++;
         end
         if (frame_done) pulses++;
         step();
      end
      checks++; if (k != NPIX) begin fails++; $display("FAIL stop_xfers: got %0d expected %0d", k, NPIX); end
      checks++; if (pulses != 1) begin fails++; $display("FAIL stop_pulses: got %0d expected 1", pulses); end
      checks++; if (busy !== 1'b0) begin fails++; $display("FAIL stop_busy: got %b expected 0", busy); end
      checks++; if (frame_count !== 16'd1) begin fails++; $display("FAIL stop_count: got %0d expected 1", frame_count); end
   endtask

   task automatic test_continuous();
      int t = 0;
      int pulses = 0;
      int sofs = 0;
      do_reset();
      drive(1'b1, 1'b1, 1'b1);
      for (int c = 0; c < 80; c++) begin
         if (req_if.req_valid && req_if.req_ready) begin
            checks++;
            if (req_if.req_x !== CW'((t % NPIX) % W) || req_if.req_y !== CW'((t % NPIX) / W) || req_if.req_sof !== (t % NPIX == 0)) begin
               fails++;
               $display("FAIL cont_xfer%0d: got (%0d,%0d) sof=%b expected (%0d,%0d) sof=%b", t,
                        req_if.req_x, req_if.req_y, req_if.req_sof, (t % NPIX) % W, (t % NPIX) / W, t % NPIX == 0);
            end
            if (req_if.req_sof) sofs++;
            t++;
         end
         if (frame_done) begin
            pulses++;
            if (pulses == 3) drive(1'b0, 1'b1, 1'b1);
         end
         step();
      end
      checks++; if (t != 3 * NPIX) begin fails++; $display("FAIL cont_xfers: got %0d expected %0d", t, 3 * NPIX); end
      checks++; if (pulses != 3) begin fails++; $display("FAIL cont_pulses: got %0d expected 3", pulses); end
      checks++; if (sofs != 3) begin fails++; $display("FAIL cont_sofs: got %0d expected 3", sofs); end
      checks++; if (frame_count !== 16'd3) begin fails++; $display("FAIL cont_count: got %0d expected 3", frame_count); end
   endtask

   task automatic test_reset_mid_frame();
      int t = 0;
      bit found = 0;
      do_reset();
      drive(1'b1, 1'b1, 1'b1);
      for (int c = 0; c < 60; c++) begin
         if (req_if.req_valid && t == NPIX + NPIX - 1) begin
            found = 1;
            break;
         end
         if (req_if.req_valid && req_if.req_ready) t++;
         step();
      end
      checks++;
      if (!found || req_if.req_x !== CW'(3) || req_if.req_y !== CW'(2) || frame_count !== 16'd1) begin
         fails++;
         $display("FAIL rmid_reach: got found=%0d (%0d,%0d) count=%0d expected 1 (3,2) count=1", found, req_if.req_x, req_if.req_y, frame_count);
      end
      reset = 1'b1;
      #1;
      step();
      checks++;
      if (req_if.req_valid !== 1'b0 || busy !== 1'b0 || frame_count !== 16'd0) begin
         fails++;
         $display("FAIL rmid_cleared: got valid=%b busy=%b count=%0d expected 0 0 0", req_if.req_valid, busy, frame_count);
      end
      reset = 1'b0;
      drive(1'b1, 1'b1, 1'b1);
      step();
      step();
      checks++;
      if (req_if.req_valid !== 1'b1 || req_if.req_x !== '0 || req_if.req_y !== '0 || req_if.req_sof !== 1'b1) begin
         fails++;
         $display("FAIL rmid_restart: got valid=%b (%0d,%0d) sof=%b expected 1 (0,0) 1", req_if.req_valid, req_if.req_x, req_if.req_y, req_if.req_sof);
      end
   endtask

`ifdef BARREL_SEQ_STALL_CNT_EN
   task automatic test_stall_count();
      do_reset();
      drive(1'b1, 1'b1, 1'b1);
      step();
      step();
      step();
      drive(1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 7; i++) begin
         checks++; if (req_if.req_valid !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL stall_cycle%0d: got valid=%b busy=%b expected 0 1", i, req_if.req_valid, busy); end
         step();
      end
      drive(1'b1, 1'b1, 1'b1);
      checks++; if (stall_count !== 32'd7) begin fails++; $display("FAIL stall_count: got %0d expected 7", stall_count); end
      drive(1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 20; i++) step();
      checks++; if (busy !== 1'b0 || stall_count !== 32'd7) begin fails++; $display("FAIL stall_keep: got busy=%b count=%0d expected 0 7", busy, stall_count); end
      drive(1'b1, 1'b1, 1'b1);
      step();
      checks++; if (stall_count !== 32'd0) begin fails++; $display("FAIL stall_clear: got %0d expected 0", stall_count); end
   endtask
`endif

   task automatic test_random();
      int   t = 0;
      int   frames = 0;
      logic prev_hold = 1'b0;
      logic prev_last = 1'b0;
      logic [CW-1:0] px = '0;
      logic [CW-1:0] py = '0;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         drive(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
         checks++; if (frame_done !== prev_last) begin fails++; $display("FAIL rnd_done_c%0d: got %b expected %b", c, frame_done, prev_last); end
         checks++; if (frame_count !== 16'(frames)) begin fails++; $display("FAIL rnd_count_c%0d: got %0d expected %0d", c, frame_count, frames); end
         if (prev_last) frames++;
         if (prev_hold) begin
            checks++;
            if (req_if.req_valid !== 1'b1 || req_if.req_x !== px || req_if.req_y !== py) begin
               fails++;
               $display("FAIL rnd_hold_c%0d: got valid=%b (%0d,%0d) expected 1 (%0d,%0d)", c, req_if.req_valid, req_if.req_x, req_if.req_y, px, py);
            end
         end else if (req_if.req_valid) begin
            checks++; if (buf_ready !== 1'b1) begin fails++; $display("FAIL rnd_rise_c%0d: got buf_ready=%b expected 1", c, buf_ready); end
         end
         prev_last = 1'b0;
         if (req_if.req_valid && req_if.req_ready) begin
            checks++;
            if (req_if.req_x !== CW'((t % NPIX) % W) || req_if.req_y !== CW'((t % NPIX) / W) ||
                req_if.req_sof !== (t % NPIX == 0) || req_if.req_eol !== ((t % NPIX) % W == W - 1)) begin
               fails++;
               $display("FAIL rnd_xfer%0d: got (%0d,%0d) sof=%b eol=%b expected (%0d,%0d)", t,
                        req_if.req_x, req_if.req_y, req_if.req_sof, req_if.req_eol, (t % NPIX) % W, (t % NPIX) / W);
            end
            prev_last = (t % NPIX == NPIX - 1);
            t++;
         end
         prev_hold = req_if.req_valid && !req_if.req_ready;
         px = req_if.req_x;
         py = req_if.req_y;
         step();
      end
      checks++; if (t < 100) begin fails++; $display("FAIL rnd_progress: got %0d transfers expected at least 100", t); end
   endtask

   initial begin
      req_if.req_ready = 1'b0;
      test_reset();
      test_basic_frame();
      test_fill_wait();
      test_backpressure();
      test_stop_at_boundary();
      test_continuous();
      test_reset_mid_frame();
`ifdef BARREL_SEQ_STALL_CNT_EN
      test_stall_count();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
